// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game sequencer: start/move/eat/respawn/over/win FSM
// Every output is registered except points, which is derived from size.
module snake_game_ctrl #(
  parameter int WIN_POINTS = 63,
  parameter int RETRY_MAX  = 8
) (
  input  logic       clk,
  input  logic       rst_game,
  input  logic       start,
  input  logic       tick,
  input  logic [2:0] dir_in,
  input  logic       apple_hit,
  input  logic       lethal_hit,
  input  logic [9:0] rnd_x,
  input  logic [8:0] rnd_y,
  output logic       move_en,
  output logic       clear_body,
  output logic [2:0] dir_out,
  output logic [9:0] apple_x,
  output logic [8:0] apple_y,
  output logic [6:0] size,
  output logic [6:0] points,
  output logic [2:0] state,
  output logic       game_over,
  output logic       win
);

  localparam int RW = $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_PLAY    = 3'd2,
    S_EAT     = 3'd3,
    S_RESPAWN = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_t;

  state_t      state_q;
  logic        move_en_q, clear_body_q, game_over_q, win_q;
  logic        tick_pending_q, apple_prev_q;
  logic [2:0]  dir_q, dir_d;
  logic [9:0]  apple_x_q;
  logic [8:0]  apple_y_q;
  logic [6:0]  size_q;
  logic [RW-1:0] retry_q;
  logic        apple_rise, rnd_ok;

  assign apple_rise = apple_hit && !apple_prev_q;
  assign rnd_ok = (rnd_x >= 10'd10) && (rnd_x <= 10'd620) &&
                  (rnd_y >= 9'd10)  && (rnd_y <= 9'd460);

  // Reversing onto the body is ignored: the reverse direction differs only in bit 1.
  always_comb begin
    dir_d = dir_q;
    if (!dir_in[2] && (dir_in != (dir_q ^ 3'b010)))
      dir_d = dir_in;
  end

  always_ff @(posedge clk or posedge rst_game) begin
    if (rst_game) begin
      state_q        <= S_IDLE;
      move_en_q      <= 1'b0;
      clear_body_q   <= 1'b0;
      game_over_q    <= 1'b0;
      win_q          <= 1'b0;
      tick_pending_q <= 1'b0;
      apple_prev_q   <= 1'b0;
      dir_q          <= 3'b000;
      apple_x_q      <= 10'd20;
      apple_y_q      <= 9'd20;
      size_q         <= 7'd1;
      retry_q        <= '0;
    end else begin
      apple_prev_q <= apple_hit;
      move_en_q    <= 1'b0;
      clear_body_q <= 1'b0;
      if (state_q != S_IDLE && !start) begin
        state_q     <= S_IDLE;
        game_over_q <= 1'b0;
        win_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q        <= S_INIT;
              clear_body_q   <= 1'b1;
              size_q         <= 7'd1;
              apple_x_q      <= 10'd20;
              apple_y_q      <= 9'd20;
              dir_q          <= 3'b000;
              tick_pending_q <= 1'b0;
              retry_q        <= '0;
            end
          end
          S_INIT: state_q <= S_PLAY;
          S_PLAY: begin
            if (lethal_hit) begin
              state_q     <= S_OVER;
              game_over_q <= 1'b1;
            end else begin
              if (tick || tick_pending_q) begin
                move_en_q      <= 1'b1;
                dir_q          <= dir_d;
                tick_pending_q <= 1'b0;
              end
              if (apple_rise) state_q <= S_EAT;
            end
          end
          S_EAT: begin
            if (tick) tick_pending_q <= 1'b1;
            if (size_q != 7'd127) size_q <= size_q + 7'd1;
            // The new points value equals the size before the increment.
            if (32'(size_q) >= WIN_POINTS) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else begin
              state_q <= S_RESPAWN;
            end
          end
          S_RESPAWN: begin
            if (tick) tick_pending_q <= 1'b1;
            if (rnd_ok) begin
              apple_x_q <= rnd_x;
              apple_y_q <= rnd_y;
              retry_q   <= '0;
              state_q   <= S_PLAY;
            end else if (retry_q == RW'(RETRY_MAX - 1)) begin
              apple_x_q <= 10'd40;
              apple_y_q <= 9'd30;
              retry_q   <= '0;
              state_q   <= S_PLAY;
            end else begin
              retry_q <= retry_q + 1'b1;
            end
          end
          S_OVER, S_WIN: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign move_en    = move_en_q;
  assign clear_body = clear_body_q;
  assign dir_out    = dir_q;
  assign apple_x    = apple_x_q;
  assign apple_y    = apple_y_q;
  assign size       = size_q;
  assign points     = size_q - 7'd1;
  assign state      = state_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_game;
  logic       start, tick, apple_hit, lethal_hit;
  logic [2:0] dir_in;
  logic [9:0] rnd_x;
  logic [8:0] rnd_y;
  logic       move_en, clear_body, game_over, win;
  logic [2:0] dir_out, state;
  logic [9:0] apple_x;
  logic [8:0] apple_y;
  logic [6:0] size, points;

  int checks = 0;
  int failures = 0;

  snake_game_ctrl #(.WIN_POINTS(63), .RETRY_MAX(8)) dut (
    .clk(clk), .rst_game(rst_game), .start(start), .tick(tick),
    .dir_in(dir_in), .apple_hit(apple_hit), .lethal_hit(lethal_hit),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .move_en(move_en), .clear_body(clear_body),
    .dir_out(dir_out), .apple_x(apple_x), .apple_y(apple_y), .size(size),
    .points(points), .state(state), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_game = 1'b1; start = 1'b0; tick = 1'b0; apple_hit = 1'b0; lethal_hit = 1'b0;
    dir_in = 3'b100; rnd_x = 10'd0; rnd_y = 9'd0;
    cyc(); cyc();
    check("rst_state", state, 0);
    check("rst_size", size, 1);
    check("rst_points", points, 0);
    check("rst_apple_x", apple_x, 20);
    check("rst_apple_y", apple_y, 20);
    check("rst_dir", dir_out, 0);
    check("rst_pulses", {move_en, clear_body, game_over, win}, 0);

    rst_game = 1'b0; start = 1'b1;
    cyc();
    check("init_state", state, 1);
    check("init_clear", clear_body, 1);
    cyc();
    check("play_state", state, 2);
    check("play_clear_off", clear_body, 0);
    check("play_size", size, 1);

    dir_in = 3'b010; tick = 1'b1; cyc(); tick = 1'b0;
    check("rev_move", move_en, 1);
    check("rev_dir_hold", dir_out, 0);
    cyc();
    check("move_pulse_end", move_en, 0);
    dir_in = 3'b001; tick = 1'b1; cyc(); tick = 1'b0; dir_in = 3'b100;
    check("turn_move", move_en, 1);
    check("turn_dir", dir_out, 1);

    rnd_x = 10'd5; rnd_y = 9'd100; apple_hit = 1'b1;
    cyc();
    check("eat_state", state, 3);
    cyc();
    check("respawn_state", state, 4);
    check("eat_size", size, 2);
    check("eat_points", points, 1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("reject_hold", state, 4);
    end
    rnd_x = 10'd300; rnd_y = 9'd200; tick = 1'b1;
    cyc(); tick = 1'b0;
    check("accept_state", state, 2);
    check("accept_apple_x", apple_x, 300);
    check("accept_apple_y", apple_y, 200);
    check("accept_no_move", move_en, 0);
    cyc();
    check("pending_move", move_en, 1);
    check("no_retrigger", state, 2);
    apple_hit = 1'b0;
    cyc();

    rnd_x = 10'd700; rnd_y = 9'd100; apple_hit = 1'b1;
    cyc(); apple_hit = 1'b0;
    check("eat2_state", state, 3);
    cyc();
    check("eat2_size", size, 3);
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("fallback_wait", state, 4);
    end
    cyc();
    check("fallback_state", state, 2);
    check("fallback_x", apple_x, 40);
    check("fallback_y", apple_y, 30);

    lethal_hit = 1'b1; apple_hit = 1'b1; tick = 1'b1;
    cyc();
    check("over_state", state, 5);
    check("over_flag", game_over, 1);
    check("over_size", size, 3);
    check("over_no_move", move_en, 0);
    cyc();
    check("over_hold", state, 5);
    check("over_hold_move", move_en, 0);
    lethal_hit = 1'b0; apple_hit = 1'b0; tick = 1'b0; start = 1'b0;
    cyc();
    check("abort_idle", state, 0);
    check("abort_flag", game_over, 0);

    start = 1'b1; cyc(); cyc();
    check("restart_size", size, 1);
    rnd_x = 10'd300; rnd_y = 9'd200;
    for (int i = 0; i < 62; i++) begin
      apple_hit = 1'b1; cyc(); apple_hit = 1'b0; cyc(); cyc();
    end
    check("grow_state", state, 2);
    check("grow_size", size, 63);
    check("grow_points", points, 62);
    apple_hit = 1'b1; cyc(); apple_hit = 1'b0;
    check("win_eat", state, 3);
    cyc();
    check("win_state", state, 6);
    check("win_flag", win, 1);
    check("win_size", size, 64);
    cyc();
    check("win_hold", state, 6);
    check("win_no_move", move_en, 0);

    start = 1'b0; cyc();
    check("win_abort", {state, win}, 0);
    start = 1'b1; cyc(); cyc();
    rnd_x = 10'd700; apple_hit = 1'b1; cyc(); apple_hit = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    check("mid_respawn", state, 4);
    rst_game = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_size", size, 1);
    check("async_apple_x", apple_x, 20);
    @(negedge clk);
    rst_game = 1'b0;
    cyc();
    check("post_rst_init", state, 1);
    cyc();
    check("post_rst_play", state, 2);
    cyc();
    check("post_rst_no_pending", move_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
